// File: rtl/dmem_bus_arbiter.sv
// Shares one data-memory port between the CPU load/store path and a host/debug
// requester. Round-robin arbitration, variable-latency memory handshake, CPU
// stall generation and a per-access timeout watchdog.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cpu_addr/wdata    CPU access address and store data
//   cpu_ctrl          {write, read, unused}; write wins if both are set
//   cpu_rdata/err     load data and timeout flag, valid in CPU_DONE
//   cpu_stall         combinational; holds the CPU while its access is pending
//   host_req/we/...   level request held until host_ack
//   host_rdata/ack    read data with a one-cycle completion pulse
//   host_err          accompanies host_ack when the access timed out
//   mem_*             memory port; strobes held until mem_ready
//   stall_cycles      saturating count of cycles with cpu_stall high
module dmem_bus_arbiter #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_ctrl,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              host_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned TMR_W   = 32;
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT) - TMR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    HOST_ACC,
    CPU_DONE,
    HOST_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_grant_host;
  logic [TMR_W-1:0] timer;
  logic             cpu_req;
  logic             grant_cpu;
  logic             grant_host;
  logic             acc_ready;
  logic             acc_timeout;
  logic             timeout_hit;
  logic             unused_ctrl;

  assign unused_ctrl = cpu_ctrl[0];
  assign cpu_req     = cpu_ctrl[2] | cpu_ctrl[1];
  assign cpu_stall   = cpu_req && (state != CPU_DONE);
  // Last ACC cycle before abort; TIMEOUT of zero never expires.
  assign timeout_hit = (TIMEOUT != 0) && (timer == TO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, grant and access-termination decode.
  always_comb begin
    state_nx    = state;
    grant_cpu   = 1'b0;
    grant_host  = 1'b0;
    acc_ready   = 1'b0;
    acc_timeout = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the side that was not served last wins.
        if (cpu_req && (!host_req || last_grant_host)) begin
          grant_cpu = 1'b1;
          state_nx  = CPU_ACC;
        end else if (host_req) begin
          grant_host = 1'b1;
          state_nx   = HOST_ACC;
        end
      end
      CPU_ACC: begin
        if (mem_ready) begin
          acc_ready = 1'b1;
          state_nx  = CPU_DONE;
        end else if (timeout_hit) begin
          acc_timeout = 1'b1;
          state_nx    = CPU_DONE;
        end
      end
      HOST_ACC: begin
        if (mem_ready) begin
          acc_ready = 1'b1;
          state_nx  = HOST_DONE;
        end else if (timeout_hit) begin
          acc_timeout = 1'b1;
          state_nx    = HOST_DONE;
        end
      end
      CPU_DONE:  state_nx = IDLE;
      HOST_DONE: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Memory port, response registers, arbitration history and watchdog timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_rd          <= 1'b0;
      mem_wr          <= 1'b0;
      cpu_rdata       <= '0;
      cpu_err         <= 1'b0;
      host_rdata      <= '0;
      host_ack        <= 1'b0;
      host_err        <= 1'b0;
      last_grant_host <= 1'b1;
      timer           <= '0;
    end else begin
      host_ack <= 1'b0;
      host_err <= 1'b0;

      if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_wr    <= cpu_ctrl[2];
        mem_rd    <= ~cpu_ctrl[2];
        cpu_err   <= 1'b0;
        timer     <= '0;
      end else if (grant_host) begin
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
        mem_wr    <= host_we;
        mem_rd    <= ~host_we;
        timer     <= '0;
      end else if (state == CPU_ACC || state == HOST_ACC) begin
        timer <= timer + TMR_W'(1);
      end

      if (acc_ready || acc_timeout) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
      end

      // Writes leave the read-data registers untouched; aborts clear them.
      if (state == CPU_ACC) begin
        if (acc_ready && mem_rd) cpu_rdata <= mem_rdata;
        if (acc_timeout) begin
          cpu_rdata <= '0;
          cpu_err   <= 1'b1;
        end
      end

      if (state == HOST_ACC) begin
        if (acc_ready && mem_rd) host_rdata <= mem_rdata;
        if (acc_timeout) host_rdata <= '0;
        if (acc_ready || acc_timeout) begin
          host_ack <= 1'b1;
          host_err <= acc_timeout;
        end
      end

      if (state == CPU_DONE)  last_grant_host <= 1'b0;
      if (state == HOST_DONE) last_grant_host <= 1'b1;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (cpu_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: stimulus pushes expected memory
// accesses and completions into queues; negedge monitors pop and compare.
module tb_dmem_bus_arbiter;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          lat;   // ACC cycle in which mem_ready rises; 0 = never
    int          cyc;   // expected strobe length; -1 = not checked
  } mem_t;

  typedef struct {
    logic [2:0]  ctrl;
    logic [63:0] addr;
    logic [63:0] wdata;
  } cpu_cmd_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } host_cmd_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          stalls; // -1 = not checked
  } cpu_exp_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } host_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_ctrl;
  logic        cpu_stall, cpu_err;
  logic        host_req, host_we, host_ack, host_err;
  logic [63:0] host_addr, host_wdata, host_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready;
  logic [31:0] stall_cycles;

  mem_t      exp_mem[$];
  cpu_cmd_t  cpu_cmds[$];
  host_cmd_t host_cmds[$];
  cpu_exp_t  exp_cpu[$];
  host_exp_t exp_host[$];

  int tests = 0;
  int fails = 0;
  logic cpu_active = 1'b0, host_active = 1'b0;
  logic cpu_done_ev = 1'b0, host_done_ev = 1'b0;

  dmem_bus_arbiter #(
    .DATA_W(64), .ADDR_W(64), .TIMEOUT(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ctrl(cpu_ctrl),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_err(host_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory model and access monitor.
  logic prev_strobe = 1'b0, have_cur = 1'b0;
  int   hold = 0;
  mem_t cur;
  logic [63:0] held_addr;
  initial begin mem_ready = 1'b0; mem_rdata = '0; end
  always @(negedge clk) begin : mem_mon
    logic strobe;
    strobe = mem_rd | mem_wr;
    if (strobe && !prev_strobe) begin
      if (exp_mem.size() == 0) begin
        tests++; fails++; have_cur = 1'b0;
        $display("FAIL mem_unexpected: access at %h, expected none", mem_addr);
      end else begin
        cur = exp_mem.pop_front();
        have_cur = 1'b1;
        chk("mem_wr", 64'(mem_wr), 64'(cur.we));
        chk("mem_rd", 64'(mem_rd), 64'(!cur.we));
        chk("mem_addr", mem_addr, cur.addr);
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      hold = 1;
      held_addr = mem_addr;
    end else if (strobe) begin
      hold++;
      chk("mem_addr_stable", mem_addr, held_addr);
    end else if (prev_strobe) begin
      if (have_cur && cur.cyc >= 0) chk("mem_strobe_cycles", 64'(hold), 64'(cur.cyc));
      have_cur = 1'b0;
    end
    mem_ready = strobe && have_cur && (cur.lat != 0) && (hold == cur.lat);
    mem_rdata = have_cur ? cur.rdata : 64'h0;
    prev_strobe = strobe;
  end

  // CPU completion monitor: CPU requesting but released means CPU_DONE.
  int stall_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_stall) stall_cnt++;
      else if (cpu_ctrl[2] | cpu_ctrl[1]) begin
        if (exp_cpu.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_unexpected: completion rdata %h, expected none", cpu_rdata);
        end else begin : pop_cpu
          cpu_exp_t e;
          e = exp_cpu.pop_front();
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("cpu_err", 64'(cpu_err), 64'(e.err));
          if (e.stalls >= 0) chk("cpu_stall_len", 64'(stall_cnt), 64'(e.stalls));
        end
        stall_cnt = 0;
        cpu_done_ev = 1'b1;
      end
    end
  end

  // Host completion monitor.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (host_ack) begin
      chk("host_ack_pulse", 64'(prev_ack), 64'h0);
      if (exp_host.size() == 0) begin
        tests++; fails++;
        $display("FAIL host_unexpected: ack rdata %h, expected none", host_rdata);
      end else begin : pop_host
        host_exp_t e;
        e = exp_host.pop_front();
        chk("host_rdata", host_rdata, e.rdata);
        chk("host_err", 64'(host_err), 64'(e.err));
      end
      host_done_ev = 1'b1;
    end
    prev_ack = host_ack;
  end

  // CPU driver: holds each command until its completion is seen.
  always begin
    @(posedge clk); #1;
    if (cpu_done_ev) begin
      cpu_done_ev = 1'b0;
      cpu_active  = 1'b0;
      cpu_ctrl    = 3'b000;
    end
    if (!cpu_active && cpu_cmds.size() != 0) begin : apply_cpu
      cpu_cmd_t c;
      c = cpu_cmds.pop_front();
      cpu_ctrl = c.ctrl; cpu_addr = c.addr; cpu_wdata = c.wdata;
      cpu_active = 1'b1;
    end
  end

  // Host driver: drops host_req for one cycle after every ack.
  always begin
    @(posedge clk); #1;
    if (host_done_ev) begin
      host_done_ev = 1'b0;
      host_active  = 1'b0;
      host_req     = 1'b0;
    end else if (!host_active && host_cmds.size() != 0) begin : apply_host
      host_cmd_t h;
      h = host_cmds.pop_front();
      host_we = h.we; host_addr = h.addr; host_wdata = h.wdata;
      host_req = 1'b1;
      host_active = 1'b1;
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((cpu_cmds.size() != 0 || host_cmds.size() != 0 || cpu_active ||
            host_active || exp_mem.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #2;
    if (n >= 400) begin
      tests++; fails++;
      $display("FAIL %s_timeout: traffic still pending after %0d cycles, expected drained", nm, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_ctrl = 3'b000; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_rd", 64'(mem_rd), 64'h0);
    chk("rst_mem_wr", 64'(mem_wr), 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_host_ack", 64'(host_ack), 64'h0);
    chk("rst_cpu_err", 64'(cpu_err), 64'h0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'h0);
    chk("rst_cpu_rdata", cpu_rdata, 64'h0);
    rst = 1'b0;

    // CPU read, ready in first ACC cycle.
    exp_mem.push_back('{1'b0, 64'h100, 64'h0, 64'hDEAD, 1, 1});
    exp_cpu.push_back('{64'hDEAD, 1'b0, 2});
    cpu_cmds.push_back('{3'b010, 64'h100, 64'h0});
    wait_idle("cpu_read");
    chk("stall_cycles_after_read", 64'(stall_cycles), 64'd2);

    // CPU store with both enables set: write wins, rdata unchanged.
    exp_mem.push_back('{1'b1, 64'h108, 64'h77, 64'h0, 1, 1});
    exp_cpu.push_back('{64'hDEAD, 1'b0, 2});
    cpu_cmds.push_back('{3'b110, 64'h108, 64'h77});
    wait_idle("cpu_write");

    // Host write, ready after 3 cycles.
    exp_mem.push_back('{1'b1, 64'h40, 64'h55, 64'h0, 3, 3});
    exp_host.push_back('{64'h0, 1'b0});
    host_cmds.push_back('{1'b1, 64'h40, 64'h55});
    wait_idle("host_write");

    // Both sides requesting continuously: grants must alternate.
    exp_mem.push_back('{1'b0, 64'h200, 64'h0,  64'h1111, 1, 1});
    exp_mem.push_back('{1'b0, 64'h300, 64'h0,  64'hAAAA, 2, 2});
    exp_mem.push_back('{1'b1, 64'h208, 64'h22, 64'h0,    2, 2});
    exp_mem.push_back('{1'b1, 64'h308, 64'hBB, 64'h0,    1, 1});
    exp_mem.push_back('{1'b0, 64'h210, 64'h0,  64'h3333, 1, 1});
    exp_mem.push_back('{1'b0, 64'h310, 64'h0,  64'hCCCC, 1, 1});
    exp_cpu.push_back('{64'h1111, 1'b0, -1});
    exp_cpu.push_back('{64'h1111, 1'b0, -1});
    exp_cpu.push_back('{64'h3333, 1'b0, -1});
    exp_host.push_back('{64'hAAAA, 1'b0});
    exp_host.push_back('{64'hAAAA, 1'b0});
    exp_host.push_back('{64'hCCCC, 1'b0});
    cpu_cmds.push_back('{3'b010, 64'h200, 64'h0});
    cpu_cmds.push_back('{3'b100, 64'h208, 64'h22});
    cpu_cmds.push_back('{3'b010, 64'h210, 64'h0});
    host_cmds.push_back('{1'b0, 64'h300, 64'h0});
    host_cmds.push_back('{1'b1, 64'h308, 64'hBB});
    host_cmds.push_back('{1'b0, 64'h310, 64'h0});
    wait_idle("round_robin");

    // CPU read with no memory response: aborted after 4 ACC cycles.
    exp_mem.push_back('{1'b0, 64'h400, 64'h0, 64'h0, 0, 4});
    exp_cpu.push_back('{64'h0, 1'b1, 5});
    cpu_cmds.push_back('{3'b010, 64'h400, 64'h0});
    wait_idle("cpu_timeout");
    repeat (3) @(negedge clk);
    chk("cpu_err_held", 64'(cpu_err), 64'h1);
    chk("cpu_rdata_aborted", cpu_rdata, 64'h0);
    chk("cpu_released", 64'(cpu_stall), 64'h0);
    exp_mem.push_back('{1'b0, 64'h408, 64'h0, 64'h99, 1, 1});
    exp_cpu.push_back('{64'h99, 1'b0, 2});
    cpu_cmds.push_back('{3'b010, 64'h408, 64'h0});
    wait_idle("cpu_err_clear");

    // Reset during a host access; pending tie afterwards goes to the CPU.
    exp_mem.push_back('{1'b1, 64'h500, 64'h66, 64'h0, 0, -1});
    host_cmds.push_back('{1'b1, 64'h500, 64'h66});
    begin : wait_wr
      int n;
      n = 0;
      while (!mem_wr && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
        tests++; fails++;
        $display("FAIL host_acc_wait: mem_wr never rose, expected 1");
      end
    end
    exp_mem.push_back('{1'b0, 64'h600, 64'h0,  64'h5A, 1, 1});
    exp_mem.push_back('{1'b1, 64'h500, 64'h66, 64'h0,  1, 1});
    exp_cpu.push_back('{64'h5A, 1'b0, -1});
    exp_host.push_back('{64'h0, 1'b0});
    cpu_cmds.push_back('{3'b010, 64'h600, 64'h0});
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_wr", 64'(mem_wr), 64'h0);
    chk("rst_async_mem_rd", 64'(mem_rd), 64'h0);
    chk("rst_async_host_ack", 64'(host_ack), 64'h0);
    chk("rst_async_stall_cycles", 64'(stall_cycles), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle("post_reset");

    chk("exp_mem_drained", 64'(exp_mem.size()), 64'h0);
    chk("exp_cpu_drained", 64'(exp_cpu.size()), 64'h0);
    chk("exp_host_drained", 64'(exp_host.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
